// File: rtl/jtdd_irq_pkg.sv
// Shared constants for the jtdd interrupt controller: register indices,
// reserved-read value and the channel-count ceiling.
package jtdd_irq_pkg;

  localparam logic [2:0] REG_PEND   = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_MODE   = 3'd2;
  localparam logic [2:0] REG_POL    = 3'd3;
  localparam logic [2:0] REG_SET    = 3'd4;
  localparam logic [2:0] REG_OVR    = 3'd5;
  localparam logic [2:0] REG_STATUS = 3'd6;

  localparam logic [7:0] RSV_RD     = 8'hFF;
  localparam int         MAX_CH     = 8;

endpackage

// File: rtl/jtdd_irq_src.sv
// One interrupt channel front end: optional 2-flop synchroniser, polarity
// normalisation and edge/level set-pulse generation.
module jtdd_irq_src #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_sig,      // raw source
  input  logic i_pol,      // current polarity (1 = active-high / rising)
  input  logic i_pol_nxt,  // polarity that will be in force after this edge
  input  logic i_mode,     // 1 = level, 0 = edge
  input  logic i_cfg_wr,   // MODE or POL being written this cycle
  output logic o_set       // hardware set pulse for PEND
);

  logic w_sig;
  logic w_s;
  logic w_s_nxt;
  logic r_prev;

  generate
    if (SYNC) begin : g_sync
      logic r_sync1;
      logic r_sync2;

      // Two-flop synchroniser for the asynchronous source.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else begin
          r_sync1 <= i_sig;
          r_sync2 <= r_sync1;
        end
      end

      assign w_sig = r_sync2;
    end else begin : g_nosync
      assign w_sig = i_sig;
    end
  endgenerate

  // Normalised source: 1 means "asserted" whatever the polarity.
  assign w_s     = w_sig ^ ~i_pol;
  assign w_s_nxt = w_sig ^ ~i_pol_nxt;

  // Edge history; on a config write it reloads from the post-write view of
  // the source so a polarity flip cannot fake an edge next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prev <= 1'b0;
    end else if (i_cfg_wr) begin
      r_prev <= w_s_nxt;
    end else begin
      r_prev <= w_s;
    end
  end

  // Set pulse: level follows s, edge fires on s 0->1; suppressed on config writes.
  always_comb begin
    o_set = 1'b0;
    if (i_cfg_wr) begin
      o_set = 1'b0;
    end else if (i_mode) begin
      o_set = w_s;
    end else begin
      o_set = w_s & ~r_prev;
    end
  end

endmodule

// File: rtl/jtdd_irqctl.sv
// Parametrised interrupt controller for the jtdd main CPU: PEND/MASK/MODE/POL
// register file, software set, write-one-to-clear and priority encoding.
// Optional sticky overrun flags are built when JTDD_IRQ_OVERRUN_EN is defined.
module jtdd_irqctl
  import jtdd_irq_pkg::*;
#(
  parameter int         CH       = 3,
  parameter bit         SYNC     = 1'b1,
  parameter logic [7:0] MODE_RST = 8'h00,
  parameter logic [7:0] POL_RST  = 8'hFF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cen,
  input  logic [CH-1:0] sig,
  input  logic          cs,
  input  logic          wr,
  input  logic [2:0]    addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [CH-1:0] irqn,
  output logic          any_irq,
  output logic [2:0]    vector
);

  logic [CH-1:0] r_pend;
  logic [CH-1:0] r_mask;
  logic [CH-1:0] r_mode;
  logic [CH-1:0] r_pol;

  logic          w_wr;
  logic [CH-1:0] w_din;
  logic [CH-1:0] w_clr;
  logic [CH-1:0] w_set_sw;
  logic [CH-1:0] w_set_hw;
  logic [CH-1:0] w_pol_nxt;
  logic          w_cfg_wr;
  logic [CH-1:0] w_act;
  logic [2:0]    w_vector;
  logic [7:0]    w_ovr_rd;
  logic          w_unused_din;

  assign w_wr         = cs & wr & cen;
  assign w_din        = din[CH-1:0];
  assign w_unused_din = ^din;

  assign w_clr     = (w_wr && addr == REG_PEND) ? w_din : {CH{1'b0}};
  assign w_set_sw  = (w_wr && addr == REG_SET)  ? w_din : {CH{1'b0}};
  assign w_cfg_wr  = w_wr && ((addr == REG_MODE) || (addr == REG_POL));
  assign w_pol_nxt = (w_wr && addr == REG_POL) ? w_din : r_pol;

  generate
    for (genvar g = 0; g < CH; g++) begin : g_src
      jtdd_irq_src #(.SYNC(SYNC)) u_src (
        .clk       (clk),
        .rstn      (rstn),
        .i_sig     (sig[g]),
        .i_pol     (r_pol[g]),
        .i_pol_nxt (w_pol_nxt[g]),
        .i_mode    (r_mode[g]),
        .i_cfg_wr  (w_cfg_wr),
        .o_set     (w_set_hw[g])
      );
    end
  endgenerate

  // Pending flags: runs every clk so no hardware event is lost; set beats clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= {CH{1'b0}};
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set_hw | w_set_sw;
    end
  end

  // Mask register (CPU RW).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mask <= {CH{1'b0}};
    end else if (w_wr && addr == REG_MASK) begin
      r_mask <= w_din;
    end else begin
      r_mask <= r_mask;
    end
  end

  // Mode register (CPU RW), 1 = level channel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode <= MODE_RST[CH-1:0];
    end else if (w_wr && addr == REG_MODE) begin
      r_mode <= w_din;
    end else begin
      r_mode <= r_mode;
    end
  end

  // Polarity register (CPU RW), 1 = active-high / rising.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pol <= POL_RST[CH-1:0];
    end else begin
      r_pol <= w_pol_nxt;
    end
  end

`ifdef JTDD_IRQ_OVERRUN_EN
  logic [CH-1:0] r_ovr;
  logic [CH-1:0] w_ovr_set;
  logic [CH-1:0] w_ovr_clr;

  assign w_ovr_set = w_set_hw & r_pend & ~w_clr;
  assign w_ovr_clr = (w_wr && addr == REG_OVR) ? w_din : {CH{1'b0}};
  assign w_ovr_rd  = 8'(r_ovr);

  // Sticky overrun flags: a new hardware event hit an unserviced request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovr <= {CH{1'b0}};
    end else begin
      r_ovr <= (r_ovr & ~w_ovr_clr) | w_ovr_set;
    end
  end
`else
  assign w_ovr_rd = 8'h00;
`endif

  assign w_act = r_pend & r_mask;

  // Priority encoder: lowest-numbered unmasked pending channel wins.
  always_comb begin
    w_vector = 3'd0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_vector = 3'(i);
      end else begin
        w_vector = w_vector;
      end
    end
  end

  assign irqn    = ~w_act;
  assign any_irq = |w_act;
  assign vector  = w_vector;

  // Combinational read mux, no side effects.
  always_comb begin
    dout = RSV_RD;
    case (addr)
      REG_PEND:   dout = 8'(r_pend);
      REG_MASK:   dout = 8'(r_mask);
      REG_MODE:   dout = 8'(r_mode);
      REG_POL:    dout = 8'(r_pol);
      REG_SET:    dout = 8'h00;
      REG_OVR:    dout = w_ovr_rd;
      REG_STATUS: dout = {any_irq, 4'b0000, w_vector};
      default:    dout = RSV_RD;
    endcase
  end

endmodule

// File: tb/tb_jtdd_irqctl.sv
// Directed self-checking bench for jtdd_irqctl (CH=3, SYNC=1).
module tb_jtdd_irqctl;
  import jtdd_irq_pkg::*;

  logic       clk;
  logic       rstn;
  logic       cen;
  logic [2:0] sig;
  logic       cs;
  logic       wr;
  logic [2:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic [2:0] irqn;
  logic       any_irq;
  logic [2:0] vector;

  int n_tests = 0;
  int n_fail  = 0;

  jtdd_irqctl #(.CH(3), .SYNC(1'b1), .MODE_RST(8'h00), .POL_RST(8'hFF)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .cen     (cen),
    .sig     (sig),
    .cs      (cs),
    .wr      (wr),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .irqn    (irqn),
    .any_irq (any_irq),
    .vector  (vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wreg(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; cen = 1'b1; addr = a; din = d;
    tick();
    cs = 1'b0; wr = 1'b0; din = 8'h00;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic chk_out(input string tag, input logic [2:0] e_irqn,
                         input logic e_any, input logic [2:0] e_vec);
    check({tag, "_irqn"}, {5'b0, irqn}, {5'b0, e_irqn});
    check({tag, "_any"},  {7'b0, any_irq}, {7'b0, e_any});
    check({tag, "_vec"},  {5'b0, vector}, {5'b0, e_vec});
  endtask

  initial begin
    rstn = 1'b0; cen = 1'b1; sig = 3'b000; cs = 1'b0; wr = 1'b0;
    addr = 3'd0; din = 8'h00;
    ticks(2);
    // Reset state
    chk_out("rst", 3'b111, 1'b0, 3'd0);
    chk_reg("rst_pend", REG_PEND, 8'h00);
    chk_reg("rst_mask", REG_MASK, 8'h00);
    chk_reg("rst_mode", REG_MODE, 8'h00);
    chk_reg("rst_pol",  REG_POL,  8'h07);
    rstn = 1'b1;
    ticks(2);

    // Rising edge on sig[1]: three-clock latency to PEND, masked output
    sig = 3'b010;
    ticks(2);
    chk_reg("lat2_pend", REG_PEND, 8'h00);
    tick();
    chk_reg("lat3_pend", REG_PEND, 8'h02);
    chk_out("masked", 3'b111, 1'b0, 3'd0);
    wreg(REG_MASK, 8'h07);
    chk_out("unmask", 3'b101, 1'b1, 3'd1);
    chk_reg("status1", REG_STATUS, 8'h81);
    wreg(REG_PEND, 8'h02);
    chk_reg("w1c1", REG_PEND, 8'h00);

    // sig[0] and sig[2] rise together
    sig = 3'b111;
    ticks(3);
    chk_reg("two_pend", REG_PEND, 8'h05);
    chk_out("two", 3'b010, 1'b1, 3'd0);
    wreg(REG_PEND, 8'h01);
    chk_reg("w1c0_pend", REG_PEND, 8'h04);
    chk_out("w1c0", 3'b011, 1'b1, 3'd2);

    // Clear of bit 1 coinciding with a new edge on sig[1]: set wins
    sig = 3'b101;
    ticks(3);
    wreg(REG_SET, 8'h02);
    chk_reg("swset", REG_PEND, 8'h06);
    sig = 3'b111;
    ticks(2);
    wreg(REG_PEND, 8'h02);
    chk_reg("setwins", REG_PEND, 8'h06);
    wreg(REG_PEND, 8'h06);
    chk_reg("w1c_all", REG_PEND, 8'h00);

    // Level mode on channel 2
    wreg(REG_MODE, 8'h04);
    chk_reg("mode_nopulse", REG_PEND, 8'h00);
    tick();
    chk_reg("level_set", REG_PEND, 8'h04);
    wreg(REG_PEND, 8'h04);
    chk_reg("level_repend", REG_PEND, 8'h04);
    sig = 3'b011;
    ticks(3);
    wreg(REG_PEND, 8'h04);
    chk_reg("level_clr", REG_PEND, 8'h00);
    tick();
    chk_reg("level_stay", REG_PEND, 8'h00);

    // Inverted polarity on channel 0: falling edge sets PEND
    wreg(REG_POL, 8'hFE);
    chk_reg("pol_rd", REG_POL, 8'h06);
    chk_reg("pol_nopulse", REG_PEND, 8'h00);
    sig = 3'b010;
    ticks(2);
    chk_reg("fall_lat2", REG_PEND, 8'h00);
    tick();
    chk_reg("fall_lat3", REG_PEND, 8'h01);
    chk_out("fall", 3'b110, 1'b1, 3'd0);

    // Software set with no source activity
    wreg(REG_SET, 8'h02);
    chk_reg("swset2", REG_PEND, 8'h03);

    // Upper bits ignored; write with cen low ignored; reserved address
    wreg(REG_MASK, 8'hFF);
    chk_reg("mask_hi", REG_MASK, 8'h07);
    cs = 1'b1; wr = 1'b1; cen = 1'b0; addr = REG_MASK; din = 8'h00;
    tick();
    cs = 1'b0; wr = 1'b0; cen = 1'b1;
    chk_reg("cen_gate", REG_MASK, 8'h07);
    chk_reg("reserved", 3'd7, 8'hFF);

`ifdef JTDD_IRQ_OVERRUN_EN
    chk_reg("ovr_clean", REG_OVR, 8'h00);
    sig = 3'b000;
    ticks(3);
    sig = 3'b010;
    ticks(3);
    chk_reg("ovr_set", REG_OVR, 8'h02);
    wreg(REG_OVR, 8'h02);
    chk_reg("ovr_clr", REG_OVR, 8'h00);
`else
    wreg(REG_OVR, 8'hFF);
    chk_reg("ovr_absent", REG_OVR, 8'h00);
`endif

    // Asynchronous reset mid-operation
    chk_reg("pre_rst", REG_PEND, 8'h03);
    #1;
    rstn = 1'b0;
    #1;
    chk_reg("async_pend", REG_PEND, 8'h00);
    chk_out("async", 3'b111, 1'b0, 3'd0);
    chk_reg("async_mask", REG_MASK, 8'h00);
    chk_reg("async_pol", REG_POL, 8'h07);
    tick();
    rstn = 1'b1;
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
